// File: rtl/eb_sub_pipe_if.sv
// Operand/result handshake bundle for the 8-bit pipelined subtractor.
// No latency of its own; carries both the input and output valid/ready pairs.
// The slave side (the subtractor) drives in_ready and the result fields.
interface eb_sub_pipe_if;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Y;
  logic       Bout;
  logic       Z;
  logic       out_valid;
  logic       out_ready;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output A, B, Bin, in_valid, out_ready,
    input  in_ready, Y, Bout, Z, out_valid
  );

  // Subtractor side.
  modport slave (
    input  A, B, Bin, in_valid, out_ready,
    output in_ready, Y, Bout, Z, out_valid
  );
endinterface

// File: rtl/eb_sub_pipe.sv
// Unsigned 8-bit subtractor Y = A - B - Bin as A + ~B + ~Bin on two 4-bit lookahead nibbles.
// Latency 2 cycles (low nibble in stage 1, high nibble in stage 2), 1 result per cycle.
// Output stalls hold Y/Bout/Z; stage 1 holds behind it and in_ready falls once it is full.
// Option: define EB_SUB_SAT_EN to clamp underflowing results to 8'h00.
module eb_sub_pipe (
  input  logic CLK,
  input  logic RST,
  input  logic VDD,
  input  logic VSS,
  eb_sub_pipe_if.slave bus
);

  // Power pins only pass through for layout; tie them off into a discarded net.
  wire unused_pwr = VDD ^ VSS;

  // 4-bit carry-lookahead adder: returns {carry_out, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Stage 1 state: finished low nibble, pending high-nibble operands and the mid carry.
  logic       s1_valid;
  logic [3:0] s1_sum_lo;
  logic [3:0] s1_a_hi;
  logic [3:0] s1_nb_hi;
  logic       s1_c4;

  logic       in_fire;
  logic       s2_load;
  logic [4:0] lo_res;
  logic [4:0] hi_res;
  logic [7:0] y_nxt;
  logic       bout_nxt;

  // Stage 2 can take stage 1 whenever the output slot is empty or being popped.
  assign s2_load      = s1_valid & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | ~bus.out_valid | bus.out_ready;
  assign in_fire      = bus.in_valid & bus.in_ready;

  // Low nibble: A + ~B + ~Bin (subtraction as two's-complement addition).
  assign lo_res = cla4(bus.A[3:0], ~bus.B[3:0], ~bus.Bin);

  // High nibble completion and result shaping; a missing carry out means a borrow.
  always_comb begin
    hi_res   = cla4(s1_a_hi, s1_nb_hi, s1_c4);
    bout_nxt = ~hi_res[4];
    y_nxt    = {hi_res[3:0], s1_sum_lo};
`ifdef EB_SUB_SAT_EN
    if (bout_nxt) y_nxt = 8'h00;
`else
`endif
  end

  // Stage 1 register: load on input transfer, otherwise empty out when drained.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s1_sum_lo <= 4'h0;
      s1_a_hi   <= 4'h0;
      s1_nb_hi  <= 4'h0;
      s1_c4     <= 1'b0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_sum_lo <= lo_res[3:0];
      s1_a_hi   <= bus.A[7:4];
      s1_nb_hi  <= ~bus.B[7:4];
      s1_c4     <= lo_res[4];
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  // Output register: load from stage 1, clear valid on a pop with nothing behind it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.out_valid <= 1'b0;
      bus.Y         <= 8'h00;
      bus.Bout      <= 1'b0;
      bus.Z         <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= 1'b1;
      bus.Y         <= y_nxt;
      bus.Bout      <= bout_nxt;
      bus.Z         <= (y_nxt == 8'h00);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eb_sub_pipe.sv
// Scoreboard bench for eb_sub_pipe: the driver queues expected results,
// a negedge monitor pops and compares every output transfer.
module tb_eb_sub_pipe;

  typedef struct {
    logic [7:0] y;
    logic       bout;
    logic       z;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic VDD = 1'b1;
  logic VSS = 1'b0;

  eb_sub_pipe_if bus();

  eb_sub_pipe dut (
    .CLK (CLK),
    .RST (RST),
    .VDD (VDD),
    .VSS (VSS),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   tests     = 0;
  int   fails     = 0;
  int   pop_cnt   = 0;
  int   acc_cnt   = 0;
  int   stall_cnt = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t       e;
    logic [8:0] d;
    d      = {1'b0, a} - {1'b0, b} - {8'h00, bin};
    e.bout = d[8];
    e.y    = d[7:0];
`ifdef EB_SUB_SAT_EN
    if (e.bout) e.y = 8'h00;
`else
`endif
    e.z = (e.y == 8'h00);
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] y, input logic bout, input logic z);
    exp_t e;
    e.y = y; e.bout = bout; e.z = z;
    return e;
  endfunction

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && bus.out_valid && bus.out_ready) begin
      pop_cnt++;
      if (q.size() == 0) begin
        check("unexpected_output", 32'(bus.Y), 32'h1ff);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result_y", 32'(bus.Y), 32'(e.y));
        check("result_bout", 32'(bus.Bout), 32'(e.bout));
        check("result_z", 32'(bus.Z), 32'(e.z));
      end
    end
  end

  // Present one operand pair and hold it until accepted (bounded).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin, input exp_t e);
    int w;
    w = 0;
    bus.A = a; bus.B = b; bus.Bin = bin; bus.in_valid = 1'b1;
    @(negedge CLK);
    while (!bus.in_ready && w < 100) begin
      w++;
      stall_cnt++;
      @(negedge CLK);
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      q.push_back(e);
      acc_cnt++;
    end
    @(posedge CLK); #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge CLK);
    #1;
    check(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_uf;
    exp_t e_eq;
    int   base;

    bus.A = 8'h00; bus.B = 8'h00; bus.Bin = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // Reset state while RST is held.
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.Y), 32'd0);
    check("rst_z", 32'(bus.Z), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Basic subtraction with a latency check.
    send(8'h5A, 8'h23, 1'b0, mk(8'h37, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    @(negedge CLK);
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    @(negedge CLK);
    check("lat_two_cycles", 32'(bus.out_valid), 32'd1);
    @(posedge CLK); #1;

    // Nibble-boundary borrow, underflow, Bin with zero result, Bin with A == B.
`ifdef EB_SUB_SAT_EN
    e_uf = mk(8'h00, 1'b1, 1'b1);
    e_eq = mk(8'h00, 1'b1, 1'b1);
`else
    e_uf = mk(8'hFF, 1'b1, 1'b0);
    e_eq = mk(8'hFF, 1'b1, 1'b0);
`endif
    send(8'h10, 8'h01, 1'b0, mk(8'h0F, 1'b0, 1'b0));
    send(8'h00, 8'h01, 1'b0, e_uf);
    send(8'h80, 8'h7F, 1'b1, mk(8'h00, 1'b0, 1'b1));
    send(8'h42, 8'h42, 1'b1, e_eq);
    send(8'hFF, 8'h00, 1'b0, mk(8'hFF, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    drain("drain_directed");

    // Back-pressure: out_ready low for 3 cycles while streaming 4 pairs.
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        send(8'h20, 8'h01, 1'b0, mk(8'h1F, 1'b0, 1'b0));
        send(8'h33, 8'h33, 1'b0, mk(8'h00, 1'b0, 1'b1));
        send(8'h01, 8'h02, 1'b0, e_uf);
        send(8'hC8, 8'h64, 1'b1, mk(8'h63, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_accepts", 32'(acc_cnt), 32'd2);
        check("bp_out_held", 32'(bus.Y), 32'h1F);
        @(posedge CLK); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    check("bp_all_accepted", 32'(acc_cnt), 32'd4);

    // Full throughput: 256 random pairs back to back.
    stall_cnt = 0;
    base = pop_cnt;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      a   = 8'($urandom);
      b   = 8'($urandom);
      bin = 1'($urandom);
      send(a, b, bin, model(a, b, bin));
    end
    bus.in_valid = 1'b0;
    check("tp_no_stalls", 32'(stall_cnt), 32'd0);
    drain("drain_throughput");
    check("tp_result_count", 32'(pop_cnt - base), 32'd256);

    // Reset with two results in flight: nothing may come out afterwards.
    bus.out_ready = 1'b0;
    send(8'h09, 8'h03, 1'b0, mk(8'h06, 1'b0, 1'b0));
    send(8'h07, 8'h07, 1'b0, mk(8'h00, 1'b0, 1'b1));
    bus.in_valid = 1'b0;
    RST = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_y", 32'(bus.Y), 32'd0);
    check("midrst_bout", 32'(bus.Bout), 32'd0);
    check("midrst_z", 32'(bus.Z), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.out_ready = 1'b1;
    base = pop_cnt;
    repeat (6) @(posedge CLK);
    #1;
    check("midrst_nothing_emitted", 32'(pop_cnt - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
